uart_tx: RTL and testbench

Byte-wide UART transmitter with an input FIFO. It serialises bytes as 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity. It is the transmit counterpart of `uart_rx` and uses the same `CLOCKS_PER_BAUD` convention, so a `uart_tx`/`uart_rx` pair with equal parameters forms a loopback link. Upstream logic pushes bytes with a valid/ready handshake, and the block drains them onto `tx_o` back-to-back.

---
 rtl/uart_tx.sv | 173 +++++++++++++++++
 tb/tb_uart_tx.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter fed by a small circular input FIFO.
// Bytes pushed with valid/ready are sent LSB first, back-to-back with no idle gap.
module uart_tx #(
    parameter int unsigned CLOCKS_PER_BAUD = 0,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       tx_o,
    output logic       busy_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [15:0]   BAUD_RELOAD = 16'(CLOCKS_PER_BAUD - 1);
    localparam logic [CW-1:0] DEPTH_CNT   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   baud_cnt_q, baud_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic baud_done;

    assign full      = (count_q == DEPTH_CNT);
    assign empty     = (count_q == '0);
    assign ready_o   = !full && rst_n;
    assign push      = valid_i && ready_o;
    assign baud_done = (baud_cnt_q == 16'd0);
    // The engine takes a byte when idle, or when a stop bit ends with more data queued.
    assign pop       = !empty && ((state_q == IDLE) || ((state_q == STOP) && baud_done));

    assign tx_o   = tx_q;
    assign busy_o = busy_q;

    // FIFO pointer and occupancy update; pointers wrap naturally at power-of-two depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_i;
    end

    // Engine state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Engine next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty) state_d = START;
            START:   if (baud_done) state_d = DATA;
            DATA:    if (baud_done && (bit_idx_q == 3'd7)) state_d = STOP;
            STOP:    if (baud_done) state_d = empty ? IDLE : START;
            default: state_d = IDLE;
        endcase
    end

    // Engine datapath and registered line/busy values for the next cycle.
    always_comb begin
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (pop) begin
                    shift_d    = mem_q[rd_ptr_q];
                    baud_cnt_d = BAUD_RELOAD;
                    tx_d       = 1'b0;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (baud_done) begin
                    tx_d       = shift_q[0];
                    bit_idx_d  = 3'd0;
                    baud_cnt_d = BAUD_RELOAD;
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (baud_done) begin
                    baud_cnt_d = BAUD_RELOAD;
                    if (bit_idx_q == 3'd7) begin
                        tx_d = 1'b1;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (baud_done) begin
                    if (pop) begin
                        shift_d    = mem_q[rd_ptr_q];
                        baud_cnt_d = BAUD_RELOAD;
                        tx_d       = 1'b0;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE) || (count_d != '0);
    end

    // Datapath and FIFO control registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            baud_cnt_q <= 16'd0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with three instances (4, 2 and 16 clocks per bit).
module tb_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic       rst4_n, valid4, ready4, tx4, busy4;
    logic [7:0] data4;
    logic       rst2_n, valid2, ready2, tx2, busy2;
    logic [7:0] data2;
    logic       rst16_n, valid16, ready16, tx16, busy16;
    logic [7:0] data16;

    uart_tx #(.CLOCKS_PER_BAUD(4), .FIFO_DEPTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst4_n), .data_i(data4), .valid_i(valid4),
        .ready_o(ready4), .tx_o(tx4), .busy_o(busy4));

    uart_tx #(.CLOCKS_PER_BAUD(2), .FIFO_DEPTH(4)) u_dut2 (
        .clk(clk), .rst_n(rst2_n), .data_i(data2), .valid_i(valid2),
        .ready_o(ready2), .tx_o(tx2), .busy_o(busy2));

    uart_tx #(.CLOCKS_PER_BAUD(16), .FIFO_DEPTH(4)) u_dut16 (
        .clk(clk), .rst_n(rst16_n), .data_i(data16), .valid_i(valid16),
        .ready_o(ready16), .tx_o(tx16), .busy_o(busy16));

    logic [7:0] rxq4 [$];
    logic [7:0] rxq16 [$];
    logic       mon4_en  = 1'b1;
    logic       mon16_en = 1'b1;

    // Expected line level for frame bit j (0 = start, 1..8 = data LSB first, 9 = stop).
    function automatic logic exp_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j >= 9) return 1'b1;
        return b[j-1];
    endfunction

    function automatic logic line_of(input int which);
        case (which)
            2:       return tx2;
            16:      return tx16;
            default: return tx4;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        repeat (n) step();
    endtask

    // Independent serial receiver: syncs on a low level, samples mid-bit.
    task automatic rx_loop(input int which, input int cpb);
        logic [7:0] b;
        logic       en;
        forever begin
            step();
            if (line_of(which) === 1'b0) begin
                step_n(cpb / 2);
                for (int j = 0; j < 8; j++) begin
                    step_n(cpb);
                    b[j] = line_of(which);
                end
                step_n(cpb);
                en = (which == 16) ? mon16_en : mon4_en;
                if (en) begin
                    checks++;
                    if (line_of(which) !== 1'b1) begin
                        failures++;
                        $display("FAIL rx_stop_bit dut%0d: got %b required 1", which, line_of(which));
                    end
                    if (which == 16) rxq16.push_back(b);
                    else             rxq4.push_back(b);
                end
            end
        end
    endtask

    initial rx_loop(4, 4);
    initial rx_loop(16, 16);

    task automatic test_reset();
        rst4_n = 1'b0; rst2_n = 1'b0; rst16_n = 1'b0;
        valid4 = 1'b0; valid2 = 1'b0; valid16 = 1'b0;
        data4 = 8'h00; data2 = 8'h00; data16 = 8'h00;
        step_n(2);
        checks++;
        if (tx4 !== 1'b1) begin failures++; $display("FAIL reset_tx4: got %b required 1", tx4); end
        checks++;
        if (busy4 !== 1'b0) begin failures++; $display("FAIL reset_busy4: got %b required 0", busy4); end
        checks++;
        if (ready4 !== 1'b0) begin failures++; $display("FAIL reset_ready4: got %b required 0", ready4); end
        checks++;
        if (tx2 !== 1'b1 || busy2 !== 1'b0) begin failures++; $display("FAIL reset_dut2: got tx=%b busy=%b required tx=1 busy=0", tx2, busy2); end
        checks++;
        if (tx16 !== 1'b1 || busy16 !== 1'b0) begin failures++; $display("FAIL reset_dut16: got tx=%b busy=%b required tx=1 busy=0", tx16, busy16); end
        rst4_n = 1'b1; rst2_n = 1'b1; rst16_n = 1'b1;
        step();
        checks++;
        if (ready4 !== 1'b1 || tx4 !== 1'b1 || busy4 !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_dut4: got ready=%b tx=%b busy=%b required 1 1 0", ready4, tx4, busy4);
        end
        step_n(4);
    endtask

    task automatic test_single_byte();
        logic e;
        data4 = 8'hA5; valid4 = 1'b1;
        step();
        valid4 = 1'b0;
        checks++;
        if (tx4 !== 1'b1) begin failures++; $display("FAIL single_early_start: got %b required 1", tx4); end
        for (int k = 0; k < 40; k++) begin
            step();
            e = exp_bit(8'hA5, k / 4);
            checks++;
            if (tx4 !== e) begin failures++; $display("FAIL single_tx cycle %0d: got %b required %b", k, tx4, e); end
            checks++;
            if (busy4 !== 1'b1) begin failures++; $display("FAIL single_busy cycle %0d: got %b required 1", k, busy4); end
        end
        step();
        checks++;
        if (tx4 !== 1'b1 || busy4 !== 1'b0) begin
            failures++;
            $display("FAIL single_end: got tx=%b busy=%b required tx=1 busy=0", tx4, busy4);
        end
        step_n(4);
    endtask

    task automatic test_back_to_back();
        logic e;
        data4 = 8'h00; valid4 = 1'b1;
        step();
        data4 = 8'hFF;
        step();
        valid4 = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (k > 0) step();
            e = (k < 40) ? exp_bit(8'h00, k / 4) : exp_bit(8'hFF, (k - 40) / 4);
            checks++;
            if (tx4 !== e) begin failures++; $display("FAIL b2b_tx cycle %0d: got %b required %b", k, tx4, e); end
            checks++;
            if (busy4 !== 1'b1) begin failures++; $display("FAIL b2b_busy cycle %0d: got %b required 1", k, busy4); end
        end
        step();
        checks++;
        if (tx4 !== 1'b1 || busy4 !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end: got tx=%b busy=%b required tx=1 busy=0", tx4, busy4);
        end
        step_n(8);
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int t = 0;
        int first_low = -1;
        int acc_time [10];
        logic a;
        rxq4.delete();
        data4 = 8'h00; valid4 = 1'b1;
        while (acc < 10 && t < 2000) begin
            a = ready4;
            step();
            t++;
            if (a) begin
                acc_time[acc] = t;
                acc++;
                data4 = data4 + 8'd1;
            end
            if (!ready4 && first_low < 0) first_low = acc;
        end
        valid4 = 1'b0;
        checks++;
        if (acc != 10) begin failures++; $display("FAIL bp_accepts: got %0d required 10", acc); end
        checks++;
        if (first_low != 5) begin failures++; $display("FAIL bp_first_full: got %0d accepts required 5", first_low); end
        if (acc == 10) begin
            checks++;
            if (acc_time[4] - acc_time[0] != 4) begin failures++; $display("FAIL bp_fill_time: got %0d required 4", acc_time[4] - acc_time[0]); end
            checks++;
            if (acc_time[5] - acc_time[0] != 42) begin failures++; $display("FAIL bp_first_refill: got %0d required 42", acc_time[5] - acc_time[0]); end
            for (int i = 6; i < 10; i++) begin
                checks++;
                if (acc_time[i] - acc_time[i-1] != 40) begin
                    failures++;
                    $display("FAIL bp_refill_gap %0d: got %0d required 40", i, acc_time[i] - acc_time[i-1]);
                end
            end
        end
        t = 0;
        while (rxq4.size() < 10 && t < 800) begin step(); t++; end
        checks++;
        if (rxq4.size() != 10) begin failures++; $display("FAIL bp_rx_count: got %0d required 10", rxq4.size()); end
        for (int i = 0; i < 10 && i < rxq4.size(); i++) begin
            checks++;
            if (rxq4[i] !== 8'(i)) begin failures++; $display("FAIL bp_rx_byte %0d: got %h required %h", i, rxq4[i], 8'(i)); end
        end
        t = 0;
        while (busy4 && t < 100) begin step(); t++; end
        step_n(8);
    endtask

    task automatic test_reset_mid_frame();
        logic e;
        int bad = 0;
        mon4_en = 1'b0;
        data4 = 8'h3C; valid4 = 1'b1;
        step();
        data4 = 8'h11;
        step();
        data4 = 8'h22;
        step();
        valid4 = 1'b0;
        step_n(16);
        checks++;
        if (tx4 !== 1'b1) begin failures++; $display("FAIL rst_pre_bit3: got %b required 1", tx4); end
        rst4_n = 1'b0;
        step();
        checks++;
        if (tx4 !== 1'b1 || busy4 !== 1'b0 || ready4 !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_frame: got tx=%b busy=%b ready=%b required 1 0 0", tx4, busy4, ready4);
        end
        rst4_n = 1'b1;
        for (int k = 0; k < 48; k++) begin
            step();
            if (tx4 !== 1'b1 || busy4 !== 1'b0 || ready4 !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL rst_idle_after: got %0d active cycles required 0", bad); end
        data4 = 8'h81; valid4 = 1'b1;
        step();
        valid4 = 1'b0;
        checks++;
        if (tx4 !== 1'b1) begin failures++; $display("FAIL rst_clean_early: got %b required 1", tx4); end
        for (int k = 0; k < 40; k++) begin
            step();
            e = exp_bit(8'h81, k / 4);
            checks++;
            if (tx4 !== e) begin failures++; $display("FAIL rst_clean_tx cycle %0d: got %b required %b", k, tx4, e); end
        end
        step();
        checks++;
        if (tx4 !== 1'b1 || busy4 !== 1'b0) begin
            failures++;
            $display("FAIL rst_clean_end: got tx=%b busy=%b required tx=1 busy=0", tx4, busy4);
        end
        step_n(4);
        mon4_en = 1'b1;
    endtask

    task automatic test_min_baud();
        logic e;
        data2 = 8'h01; valid2 = 1'b1;
        step();
        valid2 = 1'b0;
        checks++;
        if (tx2 !== 1'b1) begin failures++; $display("FAIL min_early_start: got %b required 1", tx2); end
        for (int k = 0; k < 20; k++) begin
            step();
            e = exp_bit(8'h01, k / 2);
            checks++;
            if (tx2 !== e) begin failures++; $display("FAIL min_tx cycle %0d: got %b required %b", k, tx2, e); end
        end
        step();
        checks++;
        if (tx2 !== 1'b1 || busy2 !== 1'b0) begin
            failures++;
            $display("FAIL min_end: got tx=%b busy=%b required tx=1 busy=0", tx2, busy2);
        end
    endtask

    task automatic test_loopback();
        logic [7:0] expq [$];
        int idx = 0;
        int t = 0;
        logic a;
        expq.push_back(8'h00);
        expq.push_back(8'h55);
        expq.push_back(8'hAA);
        expq.push_back(8'hFF);
        for (int i = 0; i < 256; i++) expq.push_back(8'($urandom_range(0, 255)));
        rxq16.delete();
        while (idx < 260 && t < 43000) begin
            data16 = expq[idx];
            valid16 = 1'b1;
            a = ready16;
            step();
            t++;
            if (a) idx++;
        end
        valid16 = 1'b0;
        checks++;
        if (idx != 260) begin failures++; $display("FAIL loop_push_count: got %0d required 260", idx); end
        t = 0;
        while (rxq16.size() < 260 && t < 2000) begin step(); t++; end
        checks++;
        if (rxq16.size() != 260) begin failures++; $display("FAIL loop_rx_count: got %0d required 260", rxq16.size()); end
        for (int i = 0; i < 260 && i < rxq16.size(); i++) begin
            checks++;
            if (rxq16[i] !== expq[i]) begin
                failures++;
                $display("FAIL loop_byte %0d: got %h required %h", i, rxq16[i], expq[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_frame();
        test_min_baud();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
